// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Request fields are held stable by the master until dm_ready completes the access.
interface mem_stage_if #(
    parameter int AW = 32
) ();
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_ready;
    logic [31:0]   dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ready, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ready, dm_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, data-memory access FSM, MEM/WB register.
// state  | meaning
// IDLE   | no memory access outstanding
// ACCESS | stage A holds an aligned load/store; dm_req asserted until dm_ready
module mem_stage #(
    parameter int         AW        = 32,
    parameter logic [1:0] WBSRC_MEM = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] Result_i,
    input  logic [31:0] MEMWdata_i,
    input  logic        MEMWrite_i,
    input  logic        RegWrite_i,
    input  logic [4:0]  RegDes_i,
    input  logic [1:0]  WBSrc_i,
    input  logic [31:0] LinkAddr_i,
    mem_stage_if.master dm,
    output logic        mem_stall,
    output logic [31:0] MEMFWdata,
    output logic [4:0]  MEMFW_RegDes,
    output logic        MEMFW_valid,
    output logic        load_use,
    output logic        wb_valid,
    output logic        RegWrite_o,
    output logic [4:0]  RegDes_o,
    output logic [31:0] WBdata_o,
    output logic        misalign
);
    localparam logic [1:0] WBSRC_ALU  = 2'b00;
    localparam logic [1:0] WBSRC_LINK = 2'b10;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic        a_valid_q, a_valid_d;
    logic [31:0] a_result_q, a_result_d;
    logic [31:0] a_wdata_q, a_wdata_d;
    logic        a_memwrite_q, a_memwrite_d;
    logic        a_regwrite_q, a_regwrite_d;
    logic [4:0]  a_regdes_q, a_regdes_d;
    logic [1:0]  a_wbsrc_q, a_wbsrc_d;
    logic [31:0] a_link_q, a_link_d;
    logic        wb_valid_q, wb_valid_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  regdes_q, regdes_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic        misalign_q, misalign_d;

    logic a_load, a_is_mem, a_misaligned, in_mem_aligned;

    assign a_load       = a_wbsrc_q == WBSRC_MEM;
    assign a_is_mem     = a_valid_q && (a_memwrite_q || a_load);
    assign a_misaligned = a_is_mem && (a_result_q[1:0] != 2'b00);
    // The instruction captured into stage A on this edge, if it needs the bus
    assign in_mem_aligned = ex_valid && (MEMWrite_i || WBSrc_i == WBSRC_MEM)
                            && (Result_i[1:0] == 2'b00);

    assign mem_stall = (state_q == ACCESS) && !dm.dm_ready;

    always_comb begin
        state_d      = state_q;
        a_valid_d    = a_valid_q;
        a_result_d   = a_result_q;
        a_wdata_d    = a_wdata_q;
        a_memwrite_d = a_memwrite_q;
        a_regwrite_d = a_regwrite_q;
        a_regdes_d   = a_regdes_q;
        a_wbsrc_d    = a_wbsrc_q;
        a_link_d     = a_link_q;
        wb_valid_d   = 1'b0;
        regwrite_d   = 1'b0;
        regdes_d     = regdes_q;
        wbdata_d     = wbdata_q;
        misalign_d   = misalign_q | a_misaligned;

        case (state_q)
            IDLE:    if (in_mem_aligned) state_d = ACCESS;
            ACCESS:  if (dm.dm_ready)    state_d = in_mem_aligned ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase

        if (!mem_stall) begin
            a_valid_d    = ex_valid;
            a_result_d   = Result_i;
            a_wdata_d    = MEMWdata_i;
            a_memwrite_d = MEMWrite_i;
            a_regwrite_d = RegWrite_i;
            a_regdes_d   = RegDes_i;
            a_wbsrc_d    = WBSrc_i;
            a_link_d     = LinkAddr_i;

            wb_valid_d = a_valid_q && !a_misaligned;
            regwrite_d = a_valid_q && a_regwrite_q && !a_misaligned;
            regdes_d   = a_regdes_q;
            if (a_load)                      wbdata_d = dm.dm_rdata;
            else if (a_wbsrc_q == WBSRC_LINK) wbdata_d = a_link_q;
            else                             wbdata_d = a_result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_valid_q    <= 1'b0;
            a_result_q   <= '0;
            a_wdata_q    <= '0;
            a_memwrite_q <= 1'b0;
            a_regwrite_q <= 1'b0;
            a_regdes_q   <= '0;
            a_wbsrc_q    <= WBSRC_ALU;
            a_link_q     <= '0;
            wb_valid_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            regdes_q     <= '0;
            wbdata_q     <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_valid_q    <= a_valid_d;
            a_result_q   <= a_result_d;
            a_wdata_q    <= a_wdata_d;
            a_memwrite_q <= a_memwrite_d;
            a_regwrite_q <= a_regwrite_d;
            a_regdes_q   <= a_regdes_d;
            a_wbsrc_q    <= a_wbsrc_d;
            a_link_q     <= a_link_d;
            wb_valid_q   <= wb_valid_d;
            regwrite_q   <= regwrite_d;
            regdes_q     <= regdes_d;
            wbdata_q     <= wbdata_d;
            misalign_q   <= misalign_d;
        end
    end

    // Bus fields come straight from stage A, which holds while stalled
    assign dm.dm_req   = state_q == ACCESS;
    assign dm.dm_we    = (state_q == ACCESS) && a_memwrite_q;
    assign dm.dm_addr  = a_result_q[AW-1:0];
    assign dm.dm_wdata = a_wdata_q;

    assign MEMFWdata    = (a_wbsrc_q == WBSRC_LINK) ? a_link_q : a_result_q;
    assign MEMFW_RegDes = a_regdes_q;
    assign MEMFW_valid  = a_valid_q && a_regwrite_q && (a_regdes_q != 5'd0) && !a_load;
    assign load_use     = a_valid_q && a_load && a_regwrite_q && (a_regdes_q != 5'd0);

    assign wb_valid   = wb_valid_q;
    assign RegWrite_o = regwrite_q;
    assign RegDes_o   = regdes_q;
    assign WBdata_o   = wbdata_q;
    assign misalign   = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table for ALU traffic, hand sequences
// for memory accesses, and a write-back scoreboard.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] Result_i = '0, MEMWdata_i = '0, LinkAddr_i = '0;
    logic        MEMWrite_i = 1'b0, RegWrite_i = 1'b0;
    logic [4:0]  RegDes_i = '0;
    logic [1:0]  WBSrc_i = '0;
    logic        mem_stall, MEMFW_valid, load_use, wb_valid, RegWrite_o, misalign;
    logic [31:0] MEMFWdata, WBdata_o;
    logic [4:0]  MEMFW_RegDes, RegDes_o;

    mem_stage_if #(.AW(32)) dm_bus ();

    mem_stage #(.AW(32), .WBSRC_MEM(2'b01)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .Result_i(Result_i),
        .MEMWdata_i(MEMWdata_i), .MEMWrite_i(MEMWrite_i), .RegWrite_i(RegWrite_i),
        .RegDes_i(RegDes_i), .WBSrc_i(WBSrc_i), .LinkAddr_i(LinkAddr_i),
        .dm(dm_bus), .mem_stall(mem_stall), .MEMFWdata(MEMFWdata),
        .MEMFW_RegDes(MEMFW_RegDes), .MEMFW_valid(MEMFW_valid), .load_use(load_use),
        .wb_valid(wb_valid), .RegWrite_o(RegWrite_o), .RegDes_o(RegDes_o),
        .WBdata_o(WBdata_o), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  wbsrc;
        logic [31:0] link;
        logic [31:0] exp_fw;
        logic        exp_fwv;
        logic [31:0] exp_wb;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
    } wb_t;

    vec_t vecs[6];
    wb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] wd,
                         input logic mw, input logic rw, input logic [4:0] rd,
                         input logic [1:0] wbsrc, input logic [31:0] link);
        ex_valid = v; Result_i = res; MEMWdata_i = wd; MEMWrite_i = mw;
        RegWrite_i = rw; RegDes_i = rd; WBSrc_i = wbsrc; LinkAddr_i = link;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic rw, input logic [31:0] data);
        wb_t e;
        e.rd = rd; e.rw = rw; e.data = data;
        sb.push_back(e);
    endtask

    // Scoreboard: every write-back must match the oldest expected entry
    always @(posedge clk) begin
        #1;
        if (!rst && wb_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h expected no write-back", RegDes_o, WBdata_o);
            end else begin
                wb_t e;
                e = sb.pop_front();
                if (RegDes_o !== e.rd || RegWrite_o !== e.rw || WBdata_o !== e.data) begin
                    errors++;
                    $display("FAIL wb_data: got rd=%0d rw=%b data=%h expected rd=%0d rw=%b data=%h",
                             RegDes_o, RegWrite_o, WBdata_o, e.rd, e.rw, e.data);
                end
            end
        end
    end

    initial begin
        int req_cnt, stall_cnt;
        vecs[0] = '{1'b1, 32'h1234, 5'd5, 1'b1, 2'b00, 32'hDEAD0000, 32'h1234,     1'b1, 32'h1234};
        vecs[1] = '{1'b1, 32'h0055, 5'd0, 1'b1, 2'b00, 32'h0,        32'h0055,     1'b0, 32'h0055};
        vecs[2] = '{1'b1, 32'h0077, 5'd7, 1'b1, 2'b10, 32'h40000008, 32'h40000008, 1'b1, 32'h40000008};
        vecs[3] = '{1'b1, 32'h0099, 5'd9, 1'b0, 2'b00, 32'h0,        32'h0099,     1'b0, 32'h0099};
        vecs[4] = '{1'b0, 32'hFFFF, 5'd4, 1'b1, 2'b00, 32'h0,        32'hFFFF,     1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h0ABC, 5'd3, 1'b1, 2'b11, 32'h5555,     32'h0ABC,     1'b1, 32'h0ABC};

        dm_bus.dm_ready = 1'b0;
        dm_bus.dm_rdata = '0;
        #1;
        chk("rst_dm_req", {31'd0, dm_bus.dm_req}, 0);
        chk("rst_stall", {31'd0, mem_stall}, 0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 0);
        chk("rst_misalign", {31'd0, misalign}, 0);
        chk("rst_wbdata", WBdata_o, 0);
        chk("rst_fwvalid", {31'd0, MEMFW_valid}, 0);
        step(); step();
        rst = 1'b0;

        // ALU traffic from the vector table
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].v, vecs[i].res, 32'h0, 1'b0, vecs[i].rw, vecs[i].rd, vecs[i].wbsrc, vecs[i].link);
            if (vecs[i].v) push_wb(vecs[i].rd, vecs[i].rw, vecs[i].exp_wb);
            step();
            chk($sformatf("vec%0d_fwdata", i), MEMFWdata, vecs[i].exp_fw);
            chk($sformatf("vec%0d_fwvalid", i), {31'd0, MEMFW_valid}, {31'd0, vecs[i].exp_fwv});
            chk($sformatf("vec%0d_stall", i), {31'd0, mem_stall}, 0);
            chk($sformatf("vec%0d_req", i), {31'd0, dm_bus.dm_req}, 0);
            chk($sformatf("vec%0d_loaduse", i), {31'd0, load_use}, 0);
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();

        // Load with three wait cycles
        drive(1'b1, 32'h100, 0, 1'b0, 1'b1, 5'd8, 2'b01, 0);
        push_wb(5'd8, 1'b1, 32'hCAFEF00D);
        req_cnt = 0; stall_cnt = 0;
        step();
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
        chk("ld_load_use", {31'd0, load_use}, 1);
        chk("ld_fwvalid", {31'd0, MEMFW_valid}, 0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            if (c == 3) begin
                dm_bus.dm_ready = 1'b1;
                dm_bus.dm_rdata = 32'hCAFEF00D;
                #1;
            end
            if (dm_bus.dm_req) req_cnt++;
            if (mem_stall) stall_cnt++;
            chk($sformatf("ld_addr%0d", c), dm_bus.dm_addr, 32'h100);
            chk($sformatf("ld_we%0d", c), {31'd0, dm_bus.dm_we}, 0);
        end
        chk("ld_req_cycles", req_cnt, 4);
        chk("ld_stall_cycles", stall_cnt, 3);
        step();
        dm_bus.dm_ready = 1'b0;
        chk("ld_req_done", {31'd0, dm_bus.dm_req}, 0);
        step();

        // Back-to-back store then load, memory always ready (also ready while IDLE)
        dm_bus.dm_ready = 1'b1;
        drive(1'b1, 32'h200, 32'hA5A5A5A5, 1'b1, 1'b1, 5'd4, 2'b10, 32'h3000);
        push_wb(5'd4, 1'b1, 32'h3000);
        step();
        chk("st_req", {31'd0, dm_bus.dm_req}, 1);
        chk("st_we", {31'd0, dm_bus.dm_we}, 1);
        chk("st_addr", dm_bus.dm_addr, 32'h200);
        chk("st_wdata", dm_bus.dm_wdata, 32'hA5A5A5A5);
        chk("st_stall", {31'd0, mem_stall}, 0);
        chk("st_fwvalid", {31'd0, MEMFW_valid}, 1);
        drive(1'b1, 32'h204, 0, 1'b0, 1'b1, 5'd10, 2'b01, 0);
        dm_bus.dm_rdata = 32'h11112222;
        push_wb(5'd10, 1'b1, 32'h11112222);
        step();
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b_req", {31'd0, dm_bus.dm_req}, 1);
        chk("b2b_we", {31'd0, dm_bus.dm_we}, 0);
        chk("b2b_addr", dm_bus.dm_addr, 32'h204);
        chk("b2b_stall", {31'd0, mem_stall}, 0);
        step();
        chk("b2b_idle", {31'd0, dm_bus.dm_req}, 0);
        dm_bus.dm_ready = 1'b0;
        step();

        // Misaligned load
        chk("mis_before", {31'd0, misalign}, 0);
        drive(1'b1, 32'h102, 0, 1'b0, 1'b1, 5'd6, 2'b01, 0);
        step();
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
        chk("mis_no_req", {31'd0, dm_bus.dm_req}, 0);
        chk("mis_no_stall", {31'd0, mem_stall}, 0);
        step();
        chk("mis_flag", {31'd0, misalign}, 1);
        step(); step();
        chk("mis_sticky", {31'd0, misalign}, 1);
        chk("mis_no_req2", {31'd0, dm_bus.dm_req}, 0);

        // Reset in the middle of an access
        drive(1'b1, 32'h300, 0, 1'b0, 1'b1, 5'd11, 2'b01, 0);
        step();
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
        chk("rr_req", {31'd0, dm_bus.dm_req}, 1);
        step();
        #2 rst = 1'b1;
        #1;
        chk("rr_req_drop", {31'd0, dm_bus.dm_req}, 0);
        chk("rr_stall", {31'd0, mem_stall}, 0);
        chk("rr_misalign", {31'd0, misalign}, 0);
        step();
        rst = 1'b0;
        dm_bus.dm_ready = 1'b1;
        dm_bus.dm_rdata = 32'hBAD0BAD0;
        step();
        chk("rr_idle", {31'd0, dm_bus.dm_req}, 0);
        dm_bus.dm_ready = 1'b0;
        step(); step();
        chk("rr_no_wb", {31'd0, wb_valid}, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
